// File: rtl/hex_disp_pkg.sv
// Shared constants and the nibble-to-segment table for the hex display scanner.
// Segment vectors are ordered g..a and active-low (0 = segment lit).
package hex_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex7seg_lut.sv
// Combinational hex nibble to active-low 7-segment pattern (g..a).
module hex7seg_lut
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed common-anode 7-segment driver with tear-free frame updates.
// Define HEX_DISP_LZB_EN to blank leading zero digits (digit 0 always lit).
module hex_display_scan
  import hex_disp_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  load,
  input  logic                  blank,
  output logic                  pending,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  logic [CntW-1:0]     div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] shown_q, shown_d;
  logic                pending_q, pending_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick;
  logic                frame_end;
  logic [3:0]          cur_nibble;
  logic [6:0]          cur_seg;
  logic [DIGITS-1:0]   lz_mask;

  assign tick      = (div_cnt_q == CntLast);
  assign frame_end = tick && (idx_q == IdxLast);

  // Divider and scan index
  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // Shadow/shown double buffer: shown only changes on a frame boundary.
  always_comb begin
    shadow_d  = shadow_q;
    shown_d   = shown_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d = value_in;
    end
    if (frame_end) begin
      if (load) begin
        shown_d   = value_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        shown_d   = shadow_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    cur_nibble = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_nibble = shown_q[4*k +: 4];
      end
    end
  end

  hex7seg_lut u_lut (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

`ifdef HEX_DISP_LZB_EN
  // Digit k is suppressed when it and every more-significant nibble are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      all_zero   = all_zero && (shown_q[4*k +: 4] == 4'h0);
      lz_mask[k] = all_zero;
    end
  end
`else
  always_comb begin
    lz_mask = '0;
  end
`endif

  // Anode off for the whole tick cycle so the old segments never ghost onto the next digit.
  always_comb begin
    an_d = '1;
    if (!tick && !blank) begin
      for (int k = 0; k < int'(DIGITS); k++) begin
        an_d[k] = !((idx_q == IdxW'(k)) && !lz_mask[k]);
      end
    end
    seg_d = blank ? SEG_BLANK : cur_seg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      shown_q   <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= '1;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      shown_q   <= shown_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign pending = pending_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed self-checking bench for hex_display_scan with DIGITS=4, CLK_DIV=4.
module tb_hex_display_scan;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned CLK_DIV = 4;

  // Anode sequence of one 16-cycle frame, first cycle after reset release onward.
  localparam logic [3:0] AN_SEQ [16] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                         4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
  localparam logic [3:0] AN_DIG [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
  localparam logic [6:0] SEG_1A3F [4] = '{7'h0E, 7'h30, 7'h08, 7'h79};
`ifdef HEX_DISP_LZB_EN
  localparam logic [3:0] AN_00C0 [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
`else
  localparam logic [3:0] AN_00C0 [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
`endif
  localparam logic [6:0] SEG_00C0 [2] = '{7'h40, 7'h46};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [15:0] value_in = '0;
  logic        pending;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  hex_display_scan #(
    .DIGITS  (DIGITS),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value_in (value_in),
    .load     (load),
    .blank    (blank),
    .pending  (pending),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_an", 32'(an), 32'hF);
    check_val("reset_seg", 32'(seg), 32'h7F);
    check_val("reset_pending", 32'(pending), 32'h0);

    rst_n = 1'b1;
    cyc   = 0;
    // Frame 0: zeros on every digit, anode off one cycle per tick
    for (int i = 0; i < 16; i++) begin
      step(1);
      check_val("frame0_an", 32'(an), 32'(AN_SEQ[i]));
      if (AN_SEQ[i] != 4'hF) check_val("frame0_seg", 32'(seg), 32'h40);
    end

    // Mid-frame load of 1A3F
    step(4);
    value_in = 16'h1A3F;
    load     = 1'b1;
    step(1);
    load     = 1'b0;
    value_in = '0;
    check_val("load_pending", 32'(pending), 32'h1);
    step(8);
    check_val("old_digit3_seg", 32'(seg), 32'h40);
    check_val("pending_hold", 32'(pending), 32'h1);
    step(2);
    check_val("pending_pre_boundary", 32'(pending), 32'h1);
    step(1);
    check_val("pending_cleared", 32'(pending), 32'h0);
    for (int d = 0; d < 4; d++) begin
      step(1);
      check_val("1a3f_an", 32'(an), 32'(AN_DIG[d]));
      check_val("1a3f_seg", 32'(seg), 32'(SEG_1A3F[d]));
      step(3);
    end

    // Two loads in one frame: last wins, first never shown
    step(4);
    value_in = 16'h1111;
    load     = 1'b1;
    step(1);
    load     = 1'b0;
    step(3);
    value_in = 16'h2222;
    load     = 1'b1;
    step(1);
    load     = 1'b0;
    value_in = '0;
    check_val("dbl_old_digit2", 32'(seg), 32'h08);
    check_val("dbl_pending", 32'(pending), 32'h1);
    step(7);
    check_val("dbl_pending_cleared", 32'(pending), 32'h0);
    for (int d = 0; d < 4; d++) begin
      step(1);
      check_val("2222_an", 32'(an), 32'(AN_DIG[d]));
      check_val("2222_seg", 32'(seg), 32'h24);
      step(3);
    end

    // Load exactly on the boundary cycle
    step(15);
    value_in = 16'h00C0;
    load     = 1'b1;
    step(1);
    load     = 1'b0;
    value_in = '0;
    check_val("bnd_pending", 32'(pending), 32'h0);
    for (int d = 0; d < 4; d++) begin
      step(1);
      check_val("00c0_an", 32'(an), 32'(AN_00C0[d]));
      if (d < 2) check_val("00c0_seg", 32'(seg), 32'(SEG_00C0[d]));
      check_val("bnd_pending_stays", 32'(pending), 32'h0);
      step(3);
    end

    // Blank for 10 cycles
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_val("blank_an", 32'(an), 32'hF);
      check_val("blank_seg", 32'(seg), 32'h7F);
    end
    blank = 1'b0;
    step(7);
    check_val("unblank_an", 32'(an), 32'hE);
    check_val("unblank_seg", 32'(seg), 32'h40);

    // Asynchronous reset mid-scan
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_an", 32'(an), 32'hF);
    check_val("async_rst_seg", 32'(seg), 32'h7F);
    check_val("async_rst_pending", 32'(pending), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_val("post_rst_an", 32'(an), 32'(AN_SEQ[i]));
      if (AN_SEQ[i] != 4'hF) check_val("post_rst_seg", 32'(seg), 32'h40);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
